// File: rtl/spi_xfer_ctrl_pkg.sv
// rtl/spi_xfer_ctrl_pkg.sv - shared state encoding, status codes and timer helpers
package spi_xfer_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SETUP   = 4'd1,
        ST_FETCH   = 4'd2,
        ST_LOAD    = 4'd3,
        ST_SHIFT   = 4'd4,
        ST_UNLOAD  = 4'd5,
        ST_CAPTURE = 4'd6,
        ST_GAP     = 4'd7,
        ST_HOLD    = 4'd8
    } xfer_state_e;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_ABORT   = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    // Width of the shared down-counter; covers setup/hold/gap and the shift watchdog.
    localparam int TMR_W = 8;

    // The engine must raise spi_active by L+3; timer loaded at L reads 0 at L+3.
    localparam int SHIFT_WATCH_CYC = 3;

    // Timer runs N cycles when loaded with N-1 (expire is seen in the Nth cycle).
    function automatic logic [TMR_W-1:0] tmr_preload(input int cycles);
        return (cycles > 0) ? TMR_W'(cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/spi_xfer_timer.sv
// rtl/spi_xfer_timer.sv - loadable down-counter with expire flag at zero
module spi_xfer_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins; otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - multi-byte SPI transaction sequencer around a byte shift engine
module spi_xfer_ctrl #(
    parameter int LEN_W    = 8,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 1,
    parameter int GAP_CYC  = 1
) (
    input  logic             clock_in,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] nbytes,
    input  logic             abort,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic             cs_n,
    output logic             spi_load,
    output logic             spi_unload,
    output logic [7:0]       spi_datain,
    input  logic [7:0]       spi_dataout,
    input  logic             spi_active
);

    import spi_xfer_ctrl_pkg::*;

    xfer_state_e      state_q, state_d;
    logic             cs_n_q, cs_n_d;
    logic             done_q, done_d;
    logic             rx_valid_q, rx_valid_d;
    logic [1:0]       status_q, status_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [7:0]       datain_q, datain_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             seen_q, seen_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expire;

    spi_xfer_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk_i     (clock_in),
        .rst_i     (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .expire_o  (tmr_expire)
    );

    // Next-state and register-update decode for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        cs_n_d      = cs_n_q;
        done_d      = 1'b0;
        rx_valid_d  = 1'b0;
        status_d    = status_q;
        remaining_d = remaining_q;
        datain_d    = datain_q;
        rx_data_d   = rx_data_q;
        seen_d      = seen_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    status_d = STATUS_OK;
                    if (nbytes != '0) begin
                        remaining_d = nbytes;
                        cs_n_d      = 1'b0;
                        state_d     = ST_SETUP;
                        tmr_load    = 1'b1;
                        tmr_val     = tmr_preload(CS_SETUP);
                    end else begin
                        // Empty transaction: report completion without touching cs_n.
                        done_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    status_d = STATUS_ABORT;
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_preload(CS_HOLD);
                end else if (tmr_expire) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    status_d = STATUS_ABORT;
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_preload(CS_HOLD);
                end else if (tx_valid) begin
                    datain_d = tx_data;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                seen_d   = 1'b0;
                state_d  = ST_SHIFT;
                tmr_load = 1'b1;
                tmr_val  = tmr_preload(SHIFT_WATCH_CYC);
            end
            ST_SHIFT: begin
                if (spi_active) begin
                    seen_d = 1'b1;
                end
                if (seen_q && !spi_active) begin
                    state_d = ST_UNLOAD;
                end else if (!seen_q && !spi_active && tmr_expire) begin
                    // Engine never started: abandon the byte, no unload or rx pulse.
                    status_d = STATUS_TIMEOUT;
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_preload(CS_HOLD);
                end
            end
            ST_UNLOAD: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                rx_data_d   = spi_dataout;
                rx_valid_d  = 1'b1;
                remaining_d = remaining_q - LEN_W'(1);
                if (remaining_q == LEN_W'(1)) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_preload(CS_HOLD);
                end else if (abort) begin
                    status_d = STATUS_ABORT;
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_preload(CS_HOLD);
                end else if (GAP_CYC == 0) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_preload(GAP_CYC);
                end
            end
            ST_GAP: begin
                if (abort) begin
                    status_d = STATUS_ABORT;
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_preload(CS_HOLD);
                end else if (tmr_expire) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (tmr_expire) begin
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cs_n_q      <= 1'b1;
            done_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            status_q    <= STATUS_OK;
            remaining_q <= '0;
            datain_q    <= '0;
            rx_data_q   <= '0;
            seen_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_n_q      <= cs_n_d;
            done_q      <= done_d;
            rx_valid_q  <= rx_valid_d;
            status_q    <= status_d;
            remaining_q <= remaining_d;
            datain_q    <= datain_d;
            rx_data_q   <= rx_data_d;
            seen_q      <= seen_d;
        end
    end

    // Abort gates tx_ready so no byte is accepted in the cycle the transaction ends.
    assign tx_ready   = (state_q == ST_FETCH) && !abort;
    assign busy       = (state_q != ST_IDLE);
    assign spi_load   = (state_q == ST_LOAD);
    assign spi_unload = (state_q == ST_UNLOAD);
    assign cs_n       = cs_n_q;
    assign done       = done_q;
    assign rx_valid   = rx_valid_q;
    assign status     = status_q;
    assign rx_data    = rx_data_q;
    assign spi_datain = datain_q;

endmodule
